// File: rtl/cyq_vm_param.sv
// Vending-machine controller: accumulates two coin denominations, dispenses at PRICE,
// then returns change (or a cancel refund) as one D_C pulse per credit unit.
module cyq_vm_param #(
    parameter int unsigned PRICE      = 4,
    parameter int unsigned COIN_A_VAL = 1,
    parameter int unsigned COIN_B_VAL = 2,
    parameter int unsigned CW         = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    D_in,
    input  logic          Cancel,
    output logic          D_out,
    output logic          D_C,
    output logic          Busy,
    output logic [CW-1:0] Credit
);

    localparam logic [CW-1:0] L_PRICE  = CW'(PRICE);
    localparam logic [CW-1:0] L_COIN_A = CW'(COIN_A_VAL);
    localparam logic [CW-1:0] L_COIN_B = CW'(COIN_B_VAL);
    localparam logic [CW-1:0] L_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_VEND = 2'd2,
        S_CHG  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_credit;
    logic          r_dout;
    logic          r_dc;
    logic          r_busy;

    logic [CW-1:0] w_coin_val;
    logic          w_coin;
    logic [CW-1:0] w_sum;

    // Coin B wins when both strobes are high; at most one coin per cycle.
    always_comb begin
        w_coin_val = '0;
        if (D_in[1]) begin
            w_coin_val = L_COIN_B;
        end else if (D_in[0]) begin
            w_coin_val = L_COIN_A;
        end
        w_coin = |D_in;
        w_sum  = r_credit + w_coin_val;
    end

    // Outputs are registered alongside the state so they always reflect the state just entered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_dout   <= 1'b0;
            r_dc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_dout <= 1'b0;
            r_dc   <= 1'b0;
            r_busy <= 1'b0;
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (Cancel) begin
                        if (r_credit != '0) begin
                            r_state <= S_CHG;
                            r_dc    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_coin) begin
                        r_credit <= w_sum;
                        if (w_sum >= L_PRICE) begin
                            r_state <= S_VEND;
                            r_dout  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_VEND: begin
                    r_credit <= r_credit - L_PRICE;
                    if (r_credit > L_PRICE) begin
                        r_state <= S_CHG;
                        r_dc    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CHG: begin
                    r_credit <= r_credit - L_ONE;
                    if (r_credit == L_ONE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dc   <= 1'b1;
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_credit <= '0;
                end
            endcase
        end
    end

    assign D_out  = r_dout;
    assign D_C    = r_dc;
    assign Busy   = r_busy;
    assign Credit = r_credit;

endmodule

// File: tb/tb_cyq_vm_param.sv
// Bench for cyq_vm_param: directed scenarios plus random traffic against a schedule-based
// model (each sale/refund expands into a queue of expected output cycles).
module tb_cyq_vm_param;

    localparam int unsigned PRICE = 4;
    localparam int unsigned CA    = 1;
    localparam int unsigned CB    = 2;
    localparam int unsigned CW    = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    D_in = 2'b00;
    logic          Cancel = 1'b0;
    logic          D_out;
    logic          D_C;
    logic          Busy;
    logic [CW-1:0] Credit;

    int n_tests = 0;
    int n_fail  = 0;

    cyq_vm_param #(.PRICE(PRICE), .COIN_A_VAL(CA), .COIN_B_VAL(CB), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(D_out), .D_C(D_C), .Busy(Busy), .Credit(Credit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit dout;
        bit dc;
        int credit;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{1'b0, 1'b0, 0};
    int   m_credit = 0;

    // Busy cycles come from the schedule queue; otherwise inputs act on the held credit.
    task automatic model_update(input bit rst, input logic [1:0] din, input bit cxl);
        int v, n;
        if (rst) begin
            q.delete();
            m_credit = 0;
            cur = '{1'b0, 1'b0, 0};
        end else if (cur.dout || cur.dc) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{1'b0, 1'b0, m_credit};
        end else begin
            v = din[1] ? CB : (din[0] ? CA : 0);
            if (cxl) begin
                if (m_credit > 0) begin
                    for (int k = m_credit; k >= 1; k--) q.push_back('{1'b0, 1'b1, k});
                    m_credit = 0;
                    cur = q.pop_front();
                end
            end else if (v > 0) begin
                n = m_credit + v;
                if (n >= PRICE) begin
                    for (int k = n - PRICE; k >= 1; k--) q.push_back('{1'b0, 1'b1, k});
                    m_credit = 0;
                    cur = '{1'b1, 1'b0, n};
                end else begin
                    m_credit = n;
                    cur = '{1'b0, 1'b0, n};
                end
            end
        end
    endtask

    task automatic step(input bit rst, input logic [1:0] din, input bit cxl);
        Reset  = rst;
        D_in   = din;
        Cancel = cxl;
        @(posedge Clk);
        model_update(rst, din, cxl);
        #1;
        Reset  = 1'b0;
        D_in   = 2'b00;
        Cancel = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b11, 1'b1);
        n_tests++;
        if ({D_out, D_C, Busy, Credit} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset: got dout=%b dc=%b busy=%b credit=%0d, want all 0", D_out, D_C, Busy, Credit);
        end
    endtask

    // Stimulus code per cycle: {cancel, d_in[1:0]}.
    task automatic test_exact_price();
        logic [2:0] stim [6] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        int n_dout = 0, n_dc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, stim[i][1:0], stim[i][2]);
            n_dout += int'(D_out);
            n_dc   += int'(D_C);
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL exact_price[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
        n_tests++;
        if (n_dout != 1 || n_dc != 0 || Credit !== CW'(0)) begin
            n_fail++;
            $display("FAIL exact_price_count: got dout=%0d dc=%0d credit=%0d want 1 0 0", n_dout, n_dc, Credit);
        end
    endtask

    task automatic test_vend_change();
        logic [2:0] stim [6] = '{3'b001, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
        int n_dc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, stim[i][1:0], stim[i][2]);
            n_dc += int'(D_C);
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL vend_change[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
        n_tests++;
        if (n_dc != 1) begin
            n_fail++;
            $display("FAIL vend_change_count: got %0d D_C pulses want 1", n_dc);
        end
    endtask

    task automatic test_cancel_refund();
        logic [2:0] stim [8] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        int n_dc = 0, n_dout = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, stim[i][1:0], stim[i][2]);
            n_dc   += int'(D_C);
            n_dout += int'(D_out);
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL cancel_refund[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
        n_tests++;
        if (n_dc != 3 || n_dout != 0) begin
            n_fail++;
            $display("FAIL cancel_refund_count: got dc=%0d dout=%0d want 3 0", n_dc, n_dout);
        end
    endtask

    task automatic test_priority_busy();
        logic [2:0] stim [7] = '{3'b011, 3'b010, 3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, stim[i][1:0], stim[i][2]);
            if (i == 0) begin
                n_tests++;
                if (Credit !== CW'(2)) begin
                    n_fail++;
                    $display("FAIL coin_b_priority: got credit=%0d want 2", Credit);
                end
            end
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL priority_busy[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
    endtask

    task automatic test_cancel_edge();
        logic [2:0] stim [6] = '{3'b001, 3'b101, 3'b000, 3'b000, 3'b100, 3'b000};
        int n_dc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, stim[i][1:0], stim[i][2]);
            n_dc += int'(D_C);
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL cancel_edge[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
        n_tests++;
        if (n_dc != 1 || Busy !== 1'b0 || Credit !== CW'(0)) begin
            n_fail++;
            $display("FAIL cancel_edge_final: got dc=%0d busy=%b credit=%0d want 1 0 0", n_dc, Busy, Credit);
        end
    endtask

    task automatic test_reset_mid_change();
        int n_dc = 0;
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0);
        n_tests++;
        if ({D_C, Credit} !== {1'b1, CW'(2)}) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got dc=%b credit=%0d want 1 2", D_C, Credit);
        end
        step(1'b1, 2'b00, 1'b0);
        n_tests++;
        if ({D_out, D_C, Busy, Credit} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_mid: got %b%b%b/%0d want 000/0", D_out, D_C, Busy, Credit);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 1'b0);
            n_dc += int'(D_C);
        end
        n_tests++;
        if (n_dc != 0 || Credit !== CW'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_after: got dc=%0d credit=%0d want 0 0", n_dc, Credit);
        end
    endtask

    task automatic test_random();
        bit         rst, cxl;
        logic [1:0] din;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            cxl = ($urandom_range(0, 99) < 10);
            din = ($urandom_range(0, 99) < 55) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(rst, din, cxl);
            n_tests++;
            if ({D_out, D_C, Busy, Credit} !== {cur.dout, cur.dc, cur.dout | cur.dc, CW'(cur.credit)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b%b%b/%0d want %b%b%b/%0d", i, D_out, D_C, Busy, Credit,
                         cur.dout, cur.dc, cur.dout | cur.dc, cur.credit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_vend_change();
        test_cancel_refund();
        test_priority_busy();
        test_cancel_edge();
        test_reset_mid_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
